// File: rtl/udp_tx_pkg.sv
// Shared types and defaults for the UDP transmit packetiser.
package udp_tx_pkg;

  localparam int unsigned LEN_W             = 16;
  localparam int unsigned DEF_PAYLOAD_LEN   = 32;
  localparam int unsigned DEF_FLUSH_TIMEOUT = 1024;
  localparam int unsigned DEF_GAP_CYCLES    = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/udp_tx_pkt_ctrl.sv
// Packetiser between the UDP transmit byte FIFO and the UDP/IP transmit engine.
// Mirrors FIFO occupancy, requests fixed-length packets (full or stale partial),
// drains them on demand and holds an inter-packet gap.
module udp_tx_pkt_ctrl
  import udp_tx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 7,
  parameter int unsigned PAYLOAD_LEN   = DEF_PAYLOAD_LEN,
  parameter int unsigned FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_wr_en,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        udp_tx_req,
  input  logic        udp_tx_ack,
  output logic [15:0] udp_tx_len,
  input  logic        udp_data_req,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  output logic        pkt_done,
  output logic        underrun_err
);

  localparam int unsigned OCC_W = ADDR_WIDTH + 1;
  localparam int unsigned TMR_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(1 << ADDR_WIDTH);
  localparam logic [OCC_W-1:0] PAY_LEN = OCC_W'(PAYLOAD_LEN);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(FLUSH_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);

  tx_state_e        state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] occ_min;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [OCC_W-1:0] rem_q, rem_d;
  logic             req_q, req_d;
  logic             valid_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rd_c;

  assign occ_min = (occ_q < PAY_LEN) ? occ_q : PAY_LEN;

  // Occupancy mirror: +1 per write, -1 per own read, never past full.
  always_comb begin
    occ_d = occ_q;
    if (fifo_wr_en && !rd_c && (occ_q != OCC_MAX)) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!fifo_wr_en && rd_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Packet FSM: next state, flush timer, gap counter, read enable and flags.
  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    gap_d   = gap_q;
    len_d   = len_q;
    rem_d   = rem_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rd_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        gap_d = '0;
        if ((occ_q != '0) && !fifo_wr_en) begin
          tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
        end
        if ((occ_q >= PAY_LEN) || ((occ_q != '0) && (tmr_q >= TMR_MAX))) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          tmr_d   = '0;
          len_d   = LEN_W'(occ_min);
          rem_d   = occ_min;
        end
      end
      ST_REQ: begin
        if (udp_tx_ack) begin
          req_d   = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (udp_data_req && (rem_q != '0)) begin
          if (fifo_empty) begin
            err_d = 1'b1;
          end else begin
            rd_c  = 1'b1;
            rem_d = rem_q - OCC_W'(1);
            if (rem_q == OCC_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end
        end
      end
      ST_GAP: begin
        // The pkt_done cycle is the first GAP cycle, so GAP_CYCLES more follow it.
        if (gap_q >= GAP_MAX) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      valid_q <= rd_c;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign fifo_rd_en   = rd_c;
  assign udp_tx_req   = req_q;
  assign udp_tx_len   = len_q;
  assign udp_tx_valid = valid_q;
  // FIFO output is registered, so its data lines up with the delayed valid.
  assign udp_tx_data  = valid_q ? fifo_rd_data : 8'h00;
  assign pkt_done     = done_q;
  assign underrun_err = err_q;

endmodule
